// File: rtl/axis_pad_pkg.sv
// axis_pad_pkg: shared state type and keep helpers for the frame padder.
// Helpers work on KEEP_MAX-wide vectors; callers zero-extend or truncate.
package axis_pad_pkg;

    localparam int DEF_MIN_BYTES = 60;
    localparam int KEEP_MAX      = 256;

    typedef enum logic {
        PASS = 1'b0,
        PAD  = 1'b1
    } pad_state_e;

    function automatic int unsigned keep_count(
        input logic [KEEP_MAX-1:0] keep
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + {31'd0, keep[i]};
        end
        return n;
    endfunction

    function automatic logic [KEEP_MAX-1:0] count_to_keep(
        input int unsigned n,
        input int unsigned keep_w
    );
        logic [KEEP_MAX-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            k[i] = (i < n) && (i < keep_w);
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_min_frame_pad_if.sv
// axis_min_frame_pad_if: AXI-Stream bundle with master and slave views.
// tuser is only carried on the master side of the padder.
interface axis_min_frame_pad_if #(
    parameter int DATA_W = 512
);
    localparam int KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tuser;
    logic              tready;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast,
        output tready
    );

endinterface

// File: rtl/axis_pad_out_reg.sv
// axis_pad_out_reg: one-entry output register holding a beat until taken.
// slot_free_o tells the loader a new beat may be written this cycle.
module axis_pad_out_reg #(
    parameter int DATA_W = 512
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  load_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [DATA_W/8-1:0]   keep_i,
    input  logic                  last_i,
    input  logic                  user_i,
    output logic                  slot_free_o,
    axis_min_frame_pad_if.master  m_axis
);
    localparam int KEEP_W = DATA_W / 8;

    logic              valid_q;
    logic              last_q;
    logic              user_q;
    logic [DATA_W-1:0] data_q;
    logic [KEEP_W-1:0] keep_q;

    assign slot_free_o   = !valid_q || m_axis.tready;
    assign m_axis.tvalid = valid_q;
    assign m_axis.tdata  = data_q;
    assign m_axis.tkeep  = keep_q;
    assign m_axis.tlast  = last_q;
    assign m_axis.tuser  = user_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            last_q  <= last_i;
            user_q  <= user_i;
            data_q  <= data_i;
            keep_q  <= keep_i;
        end else if (m_axis.tready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_min_frame_pad.sv
// axis_min_frame_pad: extends short AXI-Stream frames to MIN_BYTES with zeros.
// Define AXIS_PAD_OVERSIZE_CHECK_EN to flag frames above MAX_BYTES on tuser.
module axis_min_frame_pad
    import axis_pad_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int MIN_BYTES = DEF_MIN_BYTES,
    parameter int MAX_BYTES = 1514,
    parameter int CNT_W     = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axis_min_frame_pad_if.slave  s_axis,
    axis_min_frame_pad_if.master m_axis
);
    localparam int KEEP_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_BYTES);
    localparam logic [CNT_W:0]   KEEP_C = (CNT_W + 1)'(KEEP_W);

    pad_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              run_q;
    logic              slot_free;
    logic              accept;
    logic              over;
    logic [CNT_W-1:0]  nb, tot, rem0;
    logic [CNT_W:0]    sum, nr;
    logic [KEEP_W-1:0] nb_mask;
    logic              ld;
    logic [DATA_W-1:0] ld_data;
    logic [KEEP_W-1:0] ld_keep;
    logic              ld_last;
    logic              ld_user;

    // run_q keeps the input closed until the first clock after reset
    assign s_axis.tready = run_q && slot_free && (state_q == PASS);
    assign accept  = s_axis.tvalid && s_axis.tready;
    assign nb      = CNT_W'(keep_count(KEEP_MAX'(s_axis.tkeep)));
    assign sum     = {1'b0, cnt_q} + {1'b0, nb};
    assign tot     = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    assign rem0    = MIN_C - tot;
    assign nr      = {1'b0, nb} + {1'b0, rem0};
    assign nb_mask = KEEP_W'(count_to_keep(32'(nb), KEEP_W));

`ifdef AXIS_PAD_OVERSIZE_CHECK_EN
    logic flag_q, flag_d;

    assign over   = flag_q || (tot > CNT_W'(MAX_BYTES));
    assign flag_d = accept ? (!s_axis.tlast && over) : flag_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end
`else
    logic unused_max;

    assign over       = 1'b0;
    assign unused_max = (MAX_BYTES > 0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        ld      = 1'b0;
        ld_data = '0;
        ld_keep = '0;
        ld_last = 1'b0;
        ld_user = 1'b0;
        unique case (state_q)
            PASS: begin
                if (accept) begin
                    ld      = 1'b1;
                    ld_data = s_axis.tdata;
                    ld_keep = s_axis.tkeep;
                    ld_last = s_axis.tlast;
                    cnt_d   = s_axis.tlast ? '0 : tot;
                    if (s_axis.tlast) begin
                        ld_user = over;
                        if (tot < MIN_C) begin
                            ld_keep = KEEP_W'(count_to_keep(32'(nr), KEEP_W));
                            for (int b = 0; b < KEEP_W; b++) begin
                                if (!nb_mask[b]) begin
                                    ld_data[8*b +: 8] = 8'h00;
                                end
                            end
                            if (nr > KEEP_C) begin
                                ld_last = 1'b0;
                                rem_d   = CNT_W'(nr - KEEP_C);
                                state_d = PAD;
                            end
                        end
                    end
                end
            end
            PAD: begin
                if (slot_free) begin
                    ld      = 1'b1;
                    ld_keep = KEEP_W'(count_to_keep(32'(rem_q), KEEP_W));
                    if ({1'b0, rem_q} <= KEEP_C) begin
                        ld_last = 1'b1;
                        rem_d   = '0;
                        state_d = PASS;
                    end else begin
                        rem_d = rem_q - CNT_W'(KEEP_W);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= PASS;
            cnt_q   <= '0;
            rem_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            run_q   <= 1'b1;
        end
    end

    axis_pad_out_reg #(
        .DATA_W (DATA_W)
    ) u_out (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .load_i      (ld),
        .data_i      (ld_data),
        .keep_i      (ld_keep),
        .last_i      (ld_last),
        .user_i      (ld_user),
        .slot_free_o (slot_free),
        .m_axis      (m_axis)
    );

endmodule

// File: doc/axis_min_frame_pad.md
# axis_min_frame_pad

Parametrised AXI-Stream Ethernet minimum-length padder on the transmit path, between the framing/interface logic and the Ethernet MAC stream. It counts payload bytes per frame and extends any frame shorter than MIN_BYTES with zero bytes. The last input beat is widened first; whole zero beats follow if needed. Data width and minimum length are generic, and an optional oversize check flags frames longer than MAX_BYTES.

## Interface
- DATA_W, 512, stream data width in bits; multiple of 8; KEEP_W = DATA_W/8
- MIN_BYTES, 60, minimum frame length in bytes; must be ≥ 1
- MAX_BYTES, 1514, oversize threshold in bytes; used only with the macro
- CNT_W, 16, byte-counter width; saturating
- aclk  in  1  clock; all logic on the rising edge
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  DATA_W  input data
- s_axis_tkeep  in  KEEP_W  byte enables; contiguous from bit 0
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last beat of frame
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_W  output data
- m_axis_tkeep  out  KEEP_W  output byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  output last
- m_axis_tuser  out  1  frame error; meaningful on the tlast beat only
- m_axis_tready  in  1  output ready

## Operation
- FSM states:
  - PASS: forward input beats.
  - PAD: generate zero beats; input blocked.
- Byte counter `cnt` holds bytes already accepted in the current frame. For each accepted beat, `nb` = popcount(s_axis_tkeep) and `tot` = cnt + nb, saturating at 2^CNT_W−1. On a non-last beat, cnt ← tot; on the last beat, cnt ← 0.
- PASS, accepted non-last beat, or last beat with tot ≥ MIN_BYTES: beat is copied to the output register unchanged.
- PASS, accepted last beat with tot < MIN_BYTES:
  - Remaining bytes `rem` = MIN_BYTES − tot.
  - Output beat has tkeep set to the lowest min(nb+rem, KEEP_W) bits.
  - Data bytes at and above index nb are forced to zero.
  - If nb+rem ≤ KEEP_W: tlast=1 and the FSM stays in PASS.
  - Otherwise: tlast=0, rem ← rem − (KEEP_W − nb), and the FSM goes to PAD.
- PAD, per output slot:
  - Emit a zero-data beat with tkeep = lowest min(rem, KEEP_W) bits.
  - If rem ≤ KEEP_W: tlast=1, then return to PASS. Otherwise: rem ← rem − KEEP_W.
- Padded bytes are always zero. Bytes of the input beat below nb are never altered.
- Every frame is emitted with at least MIN_BYTES bytes. Frames at or above MIN_BYTES pass bit-exact.
- m_axis_tuser is 0 unless the macro feature is compiled in (see Configuration).

## Timing
- Single output register stage; latency 1 cycle from input acceptance to m_axis_tvalid.
- Output slot is free when `(!m_axis_tvalid || m_axis_tready)`.
- s_axis_tready = slot free && state==PASS. This is combinational from m_axis_tready, and combinational paths end there.
- PAD beats load on each free slot. With m_axis_tready held at 1, one beat is issued per cycle, and s_axis_tready stays low for exactly the number of PAD beats.
- While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold stable.
- Back-to-back frames: the first beat of the next frame is accepted in the cycle after the last PAD beat loads; no bubble in PASS.
- Reset (asynchronous assert, release synchronised by the system):
  - m_axis_tvalid, tlast, tuser = 0; tdata, tkeep = 0; s_axis_tready = 0.
  - state = PASS; cnt = 0; rem = 0.
  - Reset mid-frame or mid-PAD discards the partial frame. There is no resumption.
- Input with tvalid=1 and tkeep=0 counts 0 bytes and is forwarded.

## Configuration
- Macro AXIS_PAD_OVERSIZE_CHECK_EN.
- Defined: a sticky flag is set when tot > MAX_BYTES within a frame. m_axis_tuser=1 on that frame's tlast beat. The flag clears when the tlast beat is accepted at the input. Data is never truncated.
- Undefined: no flag logic; m_axis_tuser is tied to 0.

## Structure
- Package axis_pad_pkg holds:
  - the state enum (PASS, PAD);
  - function keep_count (popcount of tkeep);
  - function count_to_keep (n → lowest min(n,KEEP_W) bits set);
  - localparam default MIN_BYTES = 60.
- Sub-module axis_pad_out_reg: a one-entry output register with valid/ready holding. The FSM drives its load enable and next-beat fields.

## Test plan
- DATA_W=64: single-beat frame, tkeep=0x07, data 0x..AABBCC → 8 beats. Beat0 tkeep=0xFF with bytes 3–7 zero. Beats 1–6 tkeep=0xFF, data 0. Beat7 tkeep=0x0F, tlast=1. s_axis_tready low for 7 cycles.
- DATA_W=512: 43-byte frame, tkeep=0x7FF_FFFF_FFFF → one beat, tkeep=0x0FFF_FFFF_FFFF_FFFF, bytes 43–59 zero, tlast=1.
- DATA_W=64: 60-byte frame (7 beats 0xFF + last 0x0F), and 64-byte frame (8×0xFF) → output identical to input, latency 1, no PAD beats.
- Random m_axis_tready (50%) with mixed 1–100-byte frames → per-frame byte count = max(len, 60); payload matches; pad bytes zero; no loss or duplication.
- aresetn low during PAD beat 3 → all outputs 0 immediately. After release, a 64-byte frame passes unchanged.
- Macro defined, 1600-byte frame, MAX_BYTES=1514 → tuser=1 on tlast only; next 100-byte frame tuser=0. Macro undefined → tuser=0 for both.
